// File: rtl/pgm_pkg.sv
// Shared types and constants for the PGM graphics DDRAM path.
//   arb_state_t       : arbiter FSM states
//   REQ_*             : fixed requester indices (0 = sprite line fetch, 1 = tilemap, 2 = CPU/ROM)
//   DDRAM_SPRITE_BASE : DDRAM word address where the sprite ROM image starts
package pgm_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_t;

   localparam int unsigned REQ_SPRITE = 0;
   localparam int unsigned REQ_TILE   = 1;
   localparam int unsigned REQ_CPU    = 2;

   localparam logic [28:0] DDRAM_SPRITE_BASE = 29'h0400000;

endpackage

// File: rtl/pgm_rr_pick.sv
// Combinational round-robin picker with a sprite-fetch urgent override.
//   req_i    : per-requester request bits
//   rr_ptr_i : index searched first; the search wraps modulo NREQ
//   urgent_i : when set and the sprite requester is asking, it wins outright
//   winner_o : index of the chosen requester (valid when any_o)
//   any_o    : at least one request bit is set
module pgm_rr_pick import pgm_pkg::*; #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   rr_ptr_i,
   input  logic            urgent_i,
   output logic [PW-1:0]   winner_o,
   output logic            any_o
);

   // One extra bit so rr_ptr + offset cannot overflow before the wrap.
   localparam int unsigned SW = PW + 1;

   logic [SW-1:0] sum;
   logic [PW-1:0] idx;

   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_ptr_i} + SW'(k);
         if (sum >= SW'(NREQ)) begin
            sum = sum - SW'(NREQ);
         end
         idx = sum[PW-1:0];
         if (!any_o && req_i[idx]) begin
            any_o    = 1'b1;
            winner_o = idx;
         end
      end
      if (urgent_i && req_i[0]) begin
         winner_o = PW'(REQ_SPRITE);
      end
   end

endmodule

// File: rtl/pgm_ddram_arbiter.sv
// Shares the single DDRAM read port between the sprite, tilemap and CPU/ROM readers.
// One single-beat read is outstanding at a time; the owner is picked round-robin, with
// the sprite fetch able to jump the queue while urgent is high.
//   clk_i, reset_i      : clock, asynchronous active-high reset
//   req_i, req_addr_i   : level requests (held until rd_valid) and flattened word addresses
//   urgent_i            : sprite hblank override
//   gnt_o, rd_valid_o   : one-hot pulses for command accepted / data returned
//   rd_data_o           : registered read data, broadcast to all requesters
//   busy_o              : a read is being issued or awaited
//   ddram_*             : DDRAM read command / response interface
module pgm_ddram_arbiter import pgm_pkg::*; #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned AW   = 29,
   parameter int unsigned DW   = 64
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [NREQ-1:0]   req_i,
   input  logic [NREQ*AW-1:0] req_addr_i,
   input  logic              urgent_i,
   output logic [NREQ-1:0]   gnt_o,
   output logic [NREQ-1:0]   rd_valid_o,
   output logic [DW-1:0]     rd_data_o,
   output logic              busy_o,
   output logic              ddram_rd_o,
   output logic [AW-1:0]     ddram_addr_o,
   output logic [7:0]        ddram_burstcnt_o,
   input  logic              ddram_busy_i,
   input  logic [DW-1:0]     ddram_dout_i,
   input  logic              ddram_dout_ready_i
);

   localparam int unsigned PW = $clog2(NREQ);

   arb_state_t       state_q, state_d;
   logic [PW-1:0]    owner_q, owner_d;
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
   logic             urg_q, urg_d;
   logic             ddram_rd_q, ddram_rd_d;
   logic [AW-1:0]    ddram_addr_q, ddram_addr_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  rd_valid_q, rd_valid_d;
   logic [DW-1:0]    rd_data_q, rd_data_d;

   logic [PW-1:0]    winner;
   logic             any_req;
   logic [AW-1:0]    addr_sel;
   logic [NREQ-1:0]  owner_oh;

   pgm_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req_i    (req_i),
      .rr_ptr_i (rr_ptr_q),
      .urgent_i (urgent_i),
      .winner_o (winner),
      .any_o    (any_req)
   );

   always_comb begin
      addr_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (winner == PW'(i)) begin
            addr_sel = req_addr_i[i*AW +: AW];
         end
      end
   end

   always_comb begin
      owner_oh          = '0;
      owner_oh[owner_q] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      urg_d        = urg_q;
      ddram_rd_d   = ddram_rd_q;
      ddram_addr_d = ddram_addr_q;
      rd_data_d    = rd_data_q;
      gnt_d        = '0;
      rd_valid_d   = '0;

      unique case (state_q)
         ARB_IDLE: begin
            // Skip the rd_valid cycle: the finishing requester still has req up there.
            if (any_req && (rd_valid_q == '0)) begin
               owner_d      = winner;
               urg_d        = urgent_i && req_i[0];
               ddram_addr_d = addr_sel;
               ddram_rd_d   = 1'b1;
               state_d      = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            if (!ddram_busy_i) begin
               ddram_rd_d = 1'b0;
               gnt_d      = owner_oh;
               state_d    = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (ddram_dout_ready_i) begin
               rd_data_d  = ddram_dout_i;
               rd_valid_d = owner_oh;
               // An urgent win is an out-of-turn grant and leaves the rotation alone.
               if (!urg_q) begin
                  rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
               end
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= ARB_IDLE;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         urg_q        <= 1'b0;
         ddram_rd_q   <= 1'b0;
         ddram_addr_q <= '0;
         gnt_q        <= '0;
         rd_valid_q   <= '0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         urg_q        <= urg_d;
         ddram_rd_q   <= ddram_rd_d;
         ddram_addr_q <= ddram_addr_d;
         gnt_q        <= gnt_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
      end
   end

   assign gnt_o            = gnt_q;
   assign rd_valid_o       = rd_valid_q;
   assign rd_data_o        = rd_data_q;
   assign busy_o           = (state_q != ARB_IDLE);
   assign ddram_rd_o       = ddram_rd_q;
   assign ddram_addr_o     = ddram_addr_q;
   assign ddram_burstcnt_o = 8'd1;

endmodule
